// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
//   Shares one cache search port among NUM_REQ requesters. Requests are
//   granted round-robin and serialised: one search is outstanding at a time.
//   The hit flag and read data of each search are captured and returned to
//   the requester that owns it. A cycle budget in ARB_WAIT stops a stalled
//   cache from hanging a requester.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   req          in   per-requester request level, held until its resp_valid
//   req_addr     in   flattened addresses, slice i = [i*ADDR_W +: ADDR_W]
//   gnt          out  one-hot owner of the current transaction
//   resp_valid   out  one-hot single-cycle completion pulse
//   resp_hit     out  sticky hit flag of the completed search
//   resp_error   out  completion was caused by timeout
//   resp_data    out  data sampled from the cache on completion
//   search_cache out  one-cycle search pulse to the cache
//   address      out  address to the cache, held from ISSUE through WAIT
//   search_done  in   cache completion flag
//   hit          in   cache hit flag (may drop before search_done rises)
//   data         in   cache read data
module cache_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_hit,
  output logic                      resp_error,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      search_cache,
  output logic [ADDR_W-1:0]         address,
  input  logic                      search_done,
  input  logic                      hit,
  input  logic [DATA_W-1:0]         data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 16;
  // The counter value seen on the TIMEOUT-th sample in ARB_WAIT.
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  arb_state_e              state_q;
  logic [IDX_W-1:0]        last_q;
  logic [IDX_W-1:0]        owner_q;
  logic [NUM_REQ-1:0]      gnt_q;
  logic [NUM_REQ-1:0]      resp_valid_q;
  logic                    resp_hit_q;
  logic                    resp_error_q;
  logic [DATA_W-1:0]       resp_data_q;
  logic                    search_q;
  logic [ADDR_W-1:0]       address_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    hit_seen_q;
  logic                    done_armed_q;

  logic [IDX_W-1:0]        pick_idx_d;
  logic [NUM_REQ-1:0]      pick_oh_d;
  logic [ADDR_W-1:0]       pick_addr_d;
  logic [CNT_W-1:0]        cnt_d;
  logic                    timeout_d;
  logic                    done_d;

  // First set request bit scanning last+1, last+2, ... modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               cand;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!found && r[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = IDX_W'(cand);
      end
    end
    return sel;
  endfunction

  always_comb begin
    pick_idx_d  = rr_pick(req, last_q);
    pick_oh_d   = '0;
    pick_addr_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx_d == IDX_W'(i)) begin
        pick_oh_d[i] = 1'b1;
        pick_addr_d  = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // A done level present on entry to WAIT belongs to the previous search;
  // it only counts once a low sample has been seen in this WAIT.
  assign done_d    = search_done && done_armed_q;
  assign timeout_d = (cnt_q == CNT_LAST);
  assign cnt_d     = cnt_q + CNT_W'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      last_q       <= LAST_RESET;
      owner_q      <= '0;
      gnt_q        <= '0;
      resp_valid_q <= '0;
      resp_hit_q   <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q  <= '0;
      search_q     <= 1'b0;
      address_q    <= '0;
      cnt_q        <= '0;
      hit_seen_q   <= 1'b0;
      done_armed_q <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      search_q     <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (|req) begin
            owner_q   <= pick_idx_d;
            gnt_q     <= pick_oh_d;
            address_q <= pick_addr_d;
            search_q  <= 1'b1;
            state_q   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          cnt_q        <= '0;
          hit_seen_q   <= 1'b0;
          done_armed_q <= 1'b0;
          state_q      <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // Completion has priority over a timeout in the same cycle.
          if (done_d) begin
            resp_data_q  <= data;
            resp_hit_q   <= hit_seen_q | hit;
            resp_error_q <= 1'b0;
            resp_valid_q <= gnt_q;
            state_q      <= ARB_RESP;
          end else if (timeout_d) begin
            resp_hit_q   <= 1'b0;
            resp_error_q <= 1'b1;
            resp_valid_q <= gnt_q;
            state_q      <= ARB_RESP;
          end else begin
            cnt_q <= cnt_d;
            if (hit) begin
              hit_seen_q <= 1'b1;
            end
            if (!search_done) begin
              done_armed_q <= 1'b1;
            end
          end
        end
        ARB_RESP: begin
          last_q  <= owner_q;
          gnt_q   <= '0;
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign resp_valid   = resp_valid_q;
  assign resp_hit     = resp_hit_q;
  assign resp_error   = resp_error_q;
  assign resp_data    = resp_data_q;
  assign search_cache = search_q;
  assign address      = address_q;

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single cache search port (search_cache / address / search_done / hit / data) among NUM_REQ requesters, e.g. instruction fetch and load unit.
- Serialises requests: only one cache search is outstanding at a time.
- Captures the hit indication and data for each search and returns them to the owning requester.
- Adds a timeout so a stalled cache cannot hang a requester.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 64, data word width
TIMEOUT, 255, max cycles in ARB_WAIT before error (1..65535)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester request level; held until its resp_valid
req_addr  input  NUM_REQ*ADDR_W  flattened addresses; slice i = [i*ADDR_W +: ADDR_W]; stable while req[i] high
gnt  output  NUM_REQ  one-hot owner of the current transaction
resp_valid  output  NUM_REQ  one-hot, single-cycle completion pulse
resp_hit  output  1  sticky hit flag for the completed search
resp_error  output  1  completion caused by timeout
resp_data  output  DATA_W  data sampled from cache on completion
search_cache  output  1  one-cycle search pulse to cache
address  output  ADDR_W  address to cache, held from ARB_ISSUE through ARB_WAIT
search_done  input  1  cache completion flag
hit  input  1  cache hit flag (may drop before search_done rises)
data  input  DATA_W  cache read data

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs = 0; state = ARB_IDLE.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
  - Timeout counter = 0; hit_seen = 0; done_armed = 0.
  - Reset mid-transaction aborts it silently: no resp_valid is issued.
- ARB_IDLE:
  - If any req bit is set, pick the first set bit scanning last+1, last+2, ... modulo NUM_REQ.
  - Latch the winner index, drive gnt one-hot, latch req_addr slice into address, go to ARB_ISSUE.
  - Otherwise stay; gnt = 0.
- ARB_ISSUE:
  - search_cache = 1 for exactly this cycle.
  - Clear counter, hit_seen, done_armed; go to ARB_WAIT.
- ARB_WAIT:
  - search_cache = 0; address and gnt held; counter increments each cycle.
  - hit_seen is set if hit=1 in any cycle; it is sticky. The cache drops hit in the same cycle it raises search_done, so a hit must be captured before completion.
  - Stale-done guard: done_armed is set after search_done has been sampled 0 at least once in ARB_WAIT. search_done=1 completes the transaction only when done_armed=1.
  - On valid completion: register data into resp_data, resp_hit = hit_seen | hit, resp_error = 0; go to ARB_RESP.
  - If the counter reaches TIMEOUT first: resp_error = 1, resp_hit = 0, resp_data unchanged; go to ARB_RESP.
  - If search_done and timeout occur in the same cycle, search_done wins and resp_error = 0.
- ARB_RESP:
  - resp_valid = gnt for one cycle; last = winner index; gnt cleared; go to ARB_IDLE.
  - resp_hit, resp_error and resp_data hold until the next ARB_RESP.
- Latency:
  - Request to search_cache pulse: 2 cycles from the req rising edge (IDLE sample, ISSUE).
  - Completion to resp_valid: 1 cycle after search_done is sampled in ARB_WAIT.
- A requester dropping req mid-transaction does not cancel it; its resp_valid still pulses. Requesters must tolerate this.
- No back-to-back issue: at least one ARB_IDLE cycle separates transactions, giving the cache time to return to idle.
- resp_data is meaningful only when resp_hit = 1. On a miss/refill the cache does not drive data.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.

Test Plan:
- Single request:
  - Stimulus: req=01, req_addr0=0x0000_1A40; cache model asserts hit at WAIT+1 and search_done at WAIT+2 with data=0xDEAD_BEEF_0000_0001.
  - Required response: one search_cache pulse with address 0x0000_1A40; resp_valid=01 with resp_hit=1 and resp_data=0xDEAD_BEEF_0000_0001; gnt=0 afterwards.
- Contention:
  - Stimulus: req=11 held for 4 transactions.
  - Required response: grant order 0,1,0,1; address alternates between the two slices; exactly one search_cache pulse per transaction.
- Miss:
  - Stimulus: hit never asserted; search_done after 7 cycles.
  - Required response: resp_hit=0, resp_error=0, resp_valid to the owner.
- Timeout:
  - Stimulus: TIMEOUT=8; search_done held 0.
  - Required response: resp_valid pulses 8 cycles after entering ARB_WAIT with resp_error=1.
  - Follow-up: the next request completes normally with resp_error=0.
- Stale done:
  - Stimulus: search_done held 1 on entry to ARB_WAIT for 1 cycle, then 0, then 1.
  - Required response: completion only on the second assertion.
- Reset mid-operation:
  - Stimulus: assert reset during ARB_WAIT.
  - Required response: immediately all outputs 0 and no resp_valid; after release with req=11, requester 0 is granted first.
